ps2_key_sequencer: RTL and testbench
====================================

# ps2_key_sequencer

Sequencing controller between the PS/2 byte receiver and the character consumer (terminal/calculator front end). Tracks break (F0h) and extended (E0h) prefixes and shift state, drives the shared combinational scan-code lookup table one code at a time, and buffers the resulting ASCII characters in a small FIFO with a valid/ready output handshake.

## Interface
- FIFO_DEPTH, 4, character buffer depth; power of two, at least 2
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- scan_code  in  8  received PS/2 byte, valid with scan_valid
- scan_valid  in  1  one-cycle strobe per received byte
- lut_code  out  8  registered scan code presented to the lookup table
- lut_ascii  in  8  lookup result for lut_code, combinational; 00h = no character
- ascii_out  out  8  FIFO head character; 00h when empty
- ascii_valid  out  1  FIFO not empty
- ascii_ready  in  1  consumer accepts head when high with ascii_valid
- shift_held  out  1  OR of left (12h) and right (59h) shift held
- drop  out  1  one-cycle pulse: character lost (FIFO full) or byte lost (collision)

## Operation
- States: IDLE, EXT (after E0h), BRK (after F0h), EXT_BRK (after E0h F0h), LOOKUP.
- IDLE + byte: E0h -> EXT; F0h -> BRK; E1h -> stay IDLE, ignored; 12h/59h -> set left/right shift bit, stay IDLE; other -> lut_code <= byte, LOOKUP.
- EXT + byte: F0h -> EXT_BRK; 4Ah -> lut_code <= E0h (keypad '/'), LOOKUP; 12h/59h -> IDLE, shift unchanged; other -> lut_code <= byte, LOOKUP.
- BRK + byte: 12h/59h clears that shift bit; any byte -> IDLE, no character.
- EXT_BRK + byte: -> IDLE, no character, shift unchanged.
- LOOKUP (one cycle): sample lut_ascii; if nonzero, apply case rule (Configuration) and push; -> IDLE.
- Typematic repeats of a make code each produce a character.
- Push when FIFO full and no pop this cycle: character discarded, drop pulses.
- scan_valid during LOOKUP: byte discarded, drop pulses, state still -> IDLE.
- FIFO: circular, read/write pointers log2(FIFO_DEPTH) bits wrapping modulo depth, occupancy counter log2(FIFO_DEPTH)+1 bits. Pop when ascii_valid && ascii_ready.
- Simultaneous push and pop: both occur, occupancy unchanged; when full, push accepted (no drop). Pop on empty ignored.

## Timing
- Reset values: state IDLE, shift bits 0, lut_code 00h, FIFO empty, ascii_out 00h, ascii_valid 0, shift_held 0, drop 0.
- Reset asserted in any state, including LOOKUP or with characters queued: everything returns to reset values immediately; the pending character is lost.
- Make byte strobed in cycle N (state IDLE/EXT): lut_code valid in N+1 (LOOKUP), push at end of N+1, ascii_valid/ascii_out in N+2. Latency 2 cycles.
- shift_held updates the cycle after the shift byte strobe; it governs a character whose LOOKUP cycle follows.
- drop asserts in the cycle after the offending event, for exactly one cycle.
- ascii_out and ascii_valid are registered/FIFO-derived; no combinational path from ascii_ready to ascii_valid. Popped entry replaced by next head in the following cycle.
- Upstream guarantees at least 2 cycles between scan_valid strobes in normal use; closer strobes exercise the collision rule.

## Configuration
- PS2_CASE_FOLD_EN defined: when lut_ascii is 41h-5Ah and shift_held is 0, push lut_ascii + 20h (lowercase); with shift held, push unchanged. All other characters unchanged.
- Undefined: lut_ascii pushed unchanged regardless of shift; shift state still tracked and shift_held still driven.

## Test plan
- Reset: strobe 1Ch, assert rst_n low during LOOKUP -> ascii_valid 0, ascii_out 00h, lut_code 00h, no drop; after release, 1Ch -> single character.
- Case: 1Ch -> 61h (macro) / 41h (no macro); 12h, 1Ch -> 41h; 12h, 1Ch, F0h 12h, 1Ch -> 41h then 61h (macro); shift_held 1 then 0.
- Prefixes: F0h 1Ch -> no character; E0h 4Ah -> lut_code E0h, ascii_out 2Fh; E0h F0h 4Ah -> no character; E0h 12h -> shift_held stays 0; E1h -> ignored.
- Unmapped: strobe 76h (lookup 00h) -> no push, no drop; 5Ah -> 0Ah; 66h -> 08h.
- Overflow: ascii_ready 0, FIFO_DEPTH=4, makes 16h 1Eh 26h 25h 2Eh -> 4 queued, drop pulses once on fifth; then ascii_ready 1 -> 31h 32h 33h 34h in order, ascii_valid falls after fourth.
- Full with concurrent pop: FIFO full, ascii_ready 1 in the push cycle -> no drop, occupancy stays 4, new character last out; two strobes 1 cycle apart -> second byte dropped, drop pulses.

Source files
------------

// File: rtl/ps2_key_sequencer_if.sv
// Byte-in / character-out bus of the PS/2 key sequencer.
// The sequencer uses the slave modport; the byte source and the character consumer use master.
interface ps2_key_sequencer_if;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic [7:0] ascii_out;
   logic       ascii_valid;
   logic       ascii_ready;

   modport master (
      output scan_code,
      output scan_valid,
      output ascii_ready,
      input  ascii_out,
      input  ascii_valid
   );

   modport slave (
      input  scan_code,
      input  scan_valid,
      input  ascii_ready,
      output ascii_out,
      output ascii_valid
   );
endinterface

// File: rtl/ps2_key_sequencer.sv
// PS/2 prefix/shift tracker that drives the scan-code lookup table and queues characters.
// Optional macro PS2_CASE_FOLD_EN lowercases unshifted letters before they are queued.
module ps2_key_sequencer #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ps2_key_sequencer_if.slave   bus,
   output logic [7:0]           lut_code,
   input  logic [7:0]           lut_ascii,
   output logic                 shift_held,
   output logic                 drop
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [2:0] {
      StIdle,
      StExt,
      StBrk,
      StExtBrk,
      StLookup
   } state_e;

   state_e            state_q, state_d;
   logic              shift_l_q, shift_l_d;
   logic              shift_r_q, shift_r_d;
   logic [7:0]        lut_code_q, lut_code_d;
   logic              drop_q;
   logic              push, push_ok, pop, full, collide;
   logic [7:0]        push_data;
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q;

   assign shift_held = shift_l_q | shift_r_q;
   assign lut_code   = lut_code_q;
   assign drop       = drop_q;

   always_comb begin
      state_d    = state_q;
      shift_l_d  = shift_l_q;
      shift_r_d  = shift_r_q;
      lut_code_d = lut_code_q;
      push       = 1'b0;
      push_data  = lut_ascii;
      collide    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.scan_valid) begin
               case (bus.scan_code)
                  8'hE0:   state_d = StExt;
                  8'hF0:   state_d = StBrk;
                  8'hE1:   state_d = StIdle;
                  8'h12:   shift_l_d = 1'b1;
                  8'h59:   shift_r_d = 1'b1;
                  default: begin
                     lut_code_d = bus.scan_code;
                     state_d    = StLookup;
                  end
               endcase
            end
         end
         StExt: begin
            if (bus.scan_valid) begin
               case (bus.scan_code)
                  8'hF0:   state_d = StExtBrk;
                  // Keypad '/' shares 4Ah with '/'; the table keys it under E0h.
                  8'h4A: begin
                     lut_code_d = 8'hE0;
                     state_d    = StLookup;
                  end
                  8'h12, 8'h59: state_d = StIdle;
                  default: begin
                     lut_code_d = bus.scan_code;
                     state_d    = StLookup;
                  end
               endcase
            end
         end
         StBrk: begin
            if (bus.scan_valid) begin
               if (bus.scan_code == 8'h12) shift_l_d = 1'b0;
               if (bus.scan_code == 8'h59) shift_r_d = 1'b0;
               state_d = StIdle;
            end
         end
         StExtBrk: begin
            if (bus.scan_valid) state_d = StIdle;
         end
         StLookup: begin
            state_d = StIdle;
            collide = bus.scan_valid;
            push    = (lut_ascii != 8'h00);
`ifdef PS2_CASE_FOLD_EN
            if (lut_ascii >= 8'h41 && lut_ascii <= 8'h5A && !shift_held) begin
               push_data = lut_ascii + 8'h20;
            end
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   assign pop     = (count_q != '0) && bus.ascii_ready;
   assign full    = (count_q == CntW'(FIFO_DEPTH));
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push_ok = push && (!full || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         shift_l_q  <= 1'b0;
         shift_r_q  <= 1'b0;
         lut_code_q <= 8'h00;
         drop_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         shift_l_q  <= shift_l_d;
         shift_r_q  <= shift_r_d;
         lut_code_q <= lut_code_d;
         drop_q     <= (push && !push_ok) || collide;
         if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

   assign bus.ascii_valid = (count_q != '0);
   assign bus.ascii_out   = bus.ascii_valid ? mem_q[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Self-checking bench: directed test-plan sequences plus random byte streams,
// compared every cycle against a prefix/shift/queue reference model.
module tb_ps2_key_sequencer;

   localparam int DEPTH = 4;
`ifdef PS2_CASE_FOLD_EN
   localparam logic [7:0] PLAIN_A = 8'h61;
`else
   localparam logic [7:0] PLAIN_A = 8'h41;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] lut_code;
   logic [7:0] lut_ascii;
   logic       shift_held;
   logic       drop;

   always #5 clk = ~clk;

   ps2_key_sequencer_if bus ();

   ps2_key_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .lut_code   (lut_code),
      .lut_ascii  (lut_ascii),
      .shift_held (shift_held),
      .drop       (drop)
   );

   // External scan-code table
   function automatic logic [7:0] lut(input logic [7:0] c);
      case (c)
         8'h1C: return 8'h41;
         8'h1B: return 8'h53;
         8'h23: return 8'h44;
         8'h16: return 8'h31;
         8'h1E: return 8'h32;
         8'h26: return 8'h33;
         8'h25: return 8'h34;
         8'h2E: return 8'h35;
         8'h45: return 8'h30;
         8'h29: return 8'h20;
         8'h5A: return 8'h0A;
         8'h66: return 8'h08;
         8'h4A: return 8'h3F;
         8'hE0: return 8'h2F;
         default: return 8'h00;
      endcase
   endfunction

   assign lut_ascii = lut(lut_code);

   int n_checks = 0;
   int n_fails  = 0;
   int obs_drops = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: prefix flags, shift flags, pending lookup, character queue
   logic       m_ext, m_brk, m_shl, m_shr, m_look, m_drop;
   logic [7:0] m_code;
   logic [7:0] mq[$];

   function automatic void model_reset();
      m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_look = 0; m_drop = 0;
      m_code = 8'h00;
      mq.delete();
   endfunction

   function automatic void model_edge(input logic v, input logic [7:0] b, input logic r);
      logic       pop;
      logic       ovf;
      logic       col;
      logic [7:0] ch;
      pop = (mq.size() != 0) && r;
      ovf = 0;
      col = 0;
      if (pop) void'(mq.pop_front());
      if (m_look) begin
         ch = lut(m_code);
`ifdef PS2_CASE_FOLD_EN
         if (ch >= 8'h41 && ch <= 8'h5A && !(m_shl || m_shr)) ch = ch + 8'h20;
`endif
         col    = v;
         m_look = 0;
         if (ch != 8'h00) begin
            if (mq.size() < DEPTH) mq.push_back(ch);
            else ovf = 1;
         end
      end else if (v) begin
         if (m_brk) begin
            if (!m_ext && b == 8'h12) m_shl = 0;
            if (!m_ext && b == 8'h59) m_shr = 0;
            m_ext = 0;
            m_brk = 0;
         end else if (m_ext) begin
            m_ext = 0;
            if (b == 8'hF0) begin
               m_ext = 1;
               m_brk = 1;
            end else if (b == 8'h4A) begin
               m_code = 8'hE0;
               m_look = 1;
            end else if (b != 8'h12 && b != 8'h59) begin
               m_code = b;
               m_look = 1;
            end
         end else begin
            case (b)
               8'hE0: m_ext = 1;
               8'hF0: m_brk = 1;
               8'hE1: ;
               8'h12: m_shl = 1;
               8'h59: m_shr = 1;
               default: begin
                  m_code = b;
                  m_look = 1;
               end
            endcase
         end
      end
      m_drop = ovf || col;
   endfunction

   task automatic check_all();
      check_eq("ascii_valid", bus.ascii_valid, mq.size() != 0);
      check_eq("ascii_out", bus.ascii_out, (mq.size() != 0) ? mq[0] : 8'h00);
      check_eq("shift_held", shift_held, m_shl || m_shr);
      check_eq("drop", drop, m_drop);
      check_eq("lut_code", lut_code, m_code);
   endtask

   task automatic step(input logic v, input logic [7:0] b, input logic r);
      @(negedge clk);
      bus.scan_valid  = v;
      bus.scan_code   = b;
      bus.ascii_ready = r;
      model_edge(v, b, r);
      @(posedge clk);
      #1;
      if (drop) obs_drops++;
      check_all();
   endtask

   task automatic send(input logic [7:0] b, input logic r);
      step(1'b1, b, r);
      step(1'b0, 8'h00, r);
   endtask

   logic [7:0] picks [15] = '{8'h1C, 8'h1B, 8'h23, 8'h45, 8'h29, 8'h5A, 8'h66, 8'h76,
                              8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h4A, 8'h16};

   initial begin
      bus.scan_valid  = 1'b0;
      bus.scan_code   = 8'h00;
      bus.ascii_ready = 1'b1;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rst_lut_code", lut_code, 8'h00);
      check_eq("rst_valid", bus.ascii_valid, 1'b0);
      check_eq("rst_out", bus.ascii_out, 8'h00);
      check_eq("rst_shift", shift_held, 1'b0);
      check_eq("rst_drop", drop, 1'b0);

      // Case handling
      send(8'h1C, 1'b1);
      check_eq("case_plain", bus.ascii_out, PLAIN_A);
      send(8'h12, 1'b1);
      check_eq("shift_on", shift_held, 1'b1);
      send(8'h1C, 1'b1);
      check_eq("case_shift", bus.ascii_out, 8'h41);
      send(8'hF0, 1'b1);
      send(8'h12, 1'b1);
      check_eq("shift_off", shift_held, 1'b0);
      send(8'h1C, 1'b1);
      check_eq("case_release", bus.ascii_out, PLAIN_A);

      // Prefixes
      send(8'hF0, 1'b1);
      send(8'h1C, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      check_eq("break_nochar", bus.ascii_valid, 1'b0);
      send(8'hE0, 1'b1);
      step(1'b1, 8'h4A, 1'b1);
      check_eq("kp_slash_code", lut_code, 8'hE0);
      step(1'b0, 8'h00, 1'b1);
      check_eq("kp_slash_char", bus.ascii_out, 8'h2F);
      send(8'hE0, 1'b1);
      send(8'hF0, 1'b1);
      send(8'h4A, 1'b1);
      check_eq("ext_break_nochar", bus.ascii_valid, 1'b0);
      send(8'hE0, 1'b1);
      send(8'h12, 1'b1);
      check_eq("ext_shift_ignored", shift_held, 1'b0);
      send(8'hE1, 1'b1);
      check_eq("e1_ignored", bus.ascii_valid, 1'b0);

      // Unmapped and control characters
      obs_drops = 0;
      send(8'h76, 1'b1);
      check_eq("unmapped_nochar", bus.ascii_valid, 1'b0);
      check_eq("unmapped_nodrop", obs_drops, 0);
      send(8'h5A, 1'b1);
      check_eq("enter", bus.ascii_out, 8'h0A);
      send(8'h66, 1'b1);
      check_eq("backspace", bus.ascii_out, 8'h08);
      step(1'b0, 8'h00, 1'b1);

      // Overflow with consumer stalled
      obs_drops = 0;
      send(8'h16, 1'b0);
      send(8'h1E, 1'b0);
      send(8'h26, 1'b0);
      send(8'h25, 1'b0);
      send(8'h2E, 1'b0);
      check_eq("ovf_drops", obs_drops, 1);
      for (int i = 0; i < 4; i++) begin
         check_eq("ovf_drain", bus.ascii_out, 8'h31 + 8'(i));
         step(1'b0, 8'h00, 1'b1);
      end
      check_eq("ovf_empty", bus.ascii_valid, 1'b0);

      // Full FIFO with concurrent pop in the push cycle
      obs_drops = 0;
      send(8'h16, 1'b0);
      send(8'h1E, 1'b0);
      send(8'h26, 1'b0);
      send(8'h25, 1'b0);
      step(1'b1, 8'h2E, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      check_eq("full_pop_nodrop", obs_drops, 0);
      for (int i = 0; i < 4; i++) begin
         check_eq("full_pop_drain", bus.ascii_out, 8'h32 + 8'(i));
         step(1'b0, 8'h00, 1'b1);
      end
      check_eq("full_pop_empty", bus.ascii_valid, 1'b0);

      // Collision: second byte lands in the lookup cycle
      obs_drops = 0;
      step(1'b1, 8'h1C, 1'b1);
      step(1'b1, 8'h1B, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      check_eq("collision_drops", obs_drops, 1);

      // Reset during the lookup cycle
      step(1'b1, 8'h1C, 1'b0);
      @(negedge clk);
      bus.scan_valid = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("midrst_valid", bus.ascii_valid, 1'b0);
      check_eq("midrst_out", bus.ascii_out, 8'h00);
      check_eq("midrst_code", lut_code, 8'h00);
      check_eq("midrst_drop", drop, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      send(8'h1C, 1'b1);
      check_eq("post_rst_char", bus.ascii_out, PLAIN_A);
      step(1'b0, 8'h00, 1'b1);
      check_eq("post_rst_single", bus.ascii_valid, 1'b0);

      // Random byte streams, random consumer back-pressure, occasional collisions
      for (int n = 0; n < 400; n++) begin
         step(1'b1, picks[$urandom_range(0, 14)], $urandom_range(0, 3) != 0);
         for (int g = $urandom_range(0, 3); g > 0; g--) begin
            step(1'b0, 8'h00, $urandom_range(0, 1) != 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
